// File: rtl/hack_dbg_pkg.sv
// Shared types for the Hack debug clock-enable controller: FSM states, mode encodings and the mode-to-state mapping.
// The breakpoint feature is enabled by the HACK_DBG_BREAKPOINT_EN macro, which is used by hack_debug_controller.
package hack_dbg_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DIV   = 2'd1,
      HALT  = 2'd2,
      BREAK = 2'd3
   } dbg_state_e;

   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_DIV  = 2'b01;
   localparam logic [1:0] MODE_HALT = 2'b10;

   // Both 2'b10 and 2'b11 select HALT.
   function automatic dbg_state_e mode_to_state(input logic [1:0] mode);
      dbg_state_e st;
      case (mode)
         MODE_RUN: st = RUN;
         MODE_DIV: st = DIV;
         default:  st = HALT;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/hack_dbg_tick_gen.sv
// Divide-ratio tick generator: counts 0..max(ratio,1)-1 and flags the wrap cycle.
// A ratio that shrinks mid-count forces the wrap at the next compare.
module hack_dbg_tick_gen #(
   parameter int unsigned DIV_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic [DIV_WIDTH-1:0] ratio,
   output logic                 tick_c
);

   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] last;

   always_comb begin
      last   = (ratio == '0) ? '0 : ratio - DIV_WIDTH'(1);
      tick_c = (cnt >= last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/hack_debug_controller.sv
// CPU clock-enable generator for the Hack top level: run / divided-run / halt-and-step, instruction counter.
// Define HACK_DBG_BREAKPOINT_EN to add the PC breakpoint compare, the BREAK state and the post-break skip flag.
module hack_debug_controller
   import hack_dbg_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = 24,
   parameter int unsigned PC_WIDTH  = 16,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 i_CLK,
   input  logic                 i_RESET_n,
   input  logic [1:0]           i_Mode,
   input  logic [DIV_WIDTH-1:0] i_Div,
   input  logic                 i_Step_Req,
   input  logic [PC_WIDTH-1:0]  i_PC,
   input  logic [PC_WIDTH-1:0]  i_BP_Addr,
   input  logic                 i_BP_Valid,
   output logic                 o_CPU_EN,
   output logic                 o_Halted,
   output logic                 o_BP_Hit,
   output logic [CNT_WIDTH-1:0] o_Step_Count
);

   dbg_state_e state;
   dbg_state_e nxt_state;
   dbg_state_e mode_state;
   logic       step_q;
   logic       step_edge;
   logic       cand;
   logic       brk_step;
   logic       bp_stop;
   logic       en_nxt;
   logic       tick_c;
   logic       div_clear;

`ifdef HACK_DBG_BREAKPOINT_EN
   logic skip;
   logic skip_nxt;
   logic bp_match;
`else
   logic unused_bp;
   assign unused_bp = ^{i_PC, i_BP_Addr, i_BP_Valid};
   assign o_BP_Hit  = 1'b0;
`endif

   // Tick counter restarts whenever the FSM is not staying in DIV.
   assign div_clear = (state != DIV) || (nxt_state != DIV);

   hack_dbg_tick_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_gen (
      .clk    (i_CLK),
      .rst_n  (i_RESET_n),
      .clear  (div_clear),
      .ratio  (i_Div),
      .tick_c (tick_c)
   );

   // Next-state and enable decision; a mode change in HALT drops a coincident step edge.
   always_comb begin
      mode_state = mode_to_state(i_Mode);
      step_edge  = i_Step_Req & ~step_q;
      nxt_state  = mode_state;
      cand       = 1'b0;
      brk_step   = 1'b0;
      bp_stop    = 1'b0;
      case (state)
         RUN:  cand = 1'b1;
         DIV:  cand = tick_c;
         HALT: cand = step_edge && (mode_state == HALT);
         BREAK: begin
            if (step_edge) begin
               brk_step = 1'b1;
            end else if (mode_state != HALT) begin
               nxt_state = BREAK;
            end
         end
         default: cand = 1'b0;
      endcase
`ifdef HACK_DBG_BREAKPOINT_EN
      bp_match = i_BP_Valid && (i_PC == i_BP_Addr) && !skip;
      bp_stop  = cand && bp_match;
      if (bp_stop) begin
         nxt_state = BREAK;
      end
`endif
      en_nxt = (cand && !bp_stop) || brk_step;
`ifdef HACK_DBG_BREAKPOINT_EN
      // Skip exempts the breakpoint instruction from re-triggering until the next enable after the step.
      skip_nxt = skip;
      if (brk_step) begin
         skip_nxt = 1'b1;
      end else if (en_nxt) begin
         skip_nxt = 1'b0;
      end
`endif
   end

   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         state        <= HALT;
         step_q       <= 1'b1;
         o_CPU_EN     <= 1'b0;
         o_Halted     <= 1'b1;
         o_Step_Count <= '0;
`ifdef HACK_DBG_BREAKPOINT_EN
         o_BP_Hit     <= 1'b0;
         skip         <= 1'b0;
`endif
      end else begin
         state        <= nxt_state;
         step_q       <= i_Step_Req;
         o_CPU_EN     <= en_nxt;
         o_Halted     <= (nxt_state == HALT) || (nxt_state == BREAK);
         o_Step_Count <= o_Step_Count + CNT_WIDTH'(en_nxt);
`ifdef HACK_DBG_BREAKPOINT_EN
         o_BP_Hit     <= (nxt_state == BREAK);
         skip         <= skip_nxt;
`endif
      end
   end

endmodule
